// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment display driver.
// A prescaler divides clk into digit slots; a 2-bit index walks the digits once per frame.
// New data is staged in a pending register and only reaches the shadow (displayed) register
// at a frame boundary, so the visible value never changes mid-frame.
// All display outputs are registered, one cycle behind the scan state.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg7_scan_display #(
  parameter int unsigned SCAN_PERIOD  = 100_000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned DP_POS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(SCAN_PERIOD - 1);
  localparam logic [PW-1:0] BlankLen = PW'(BLANK_CYCLES);
  localparam logic [1:0]    DpIdx    = 2'(DP_POS);

  localparam logic [6:0] SegOff  = 7'b1111111;
  localparam logic [6:0] SegDash = 7'b0111111;

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  // Data path state
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic        pend_flag_q, pend_flag_d;

  // Registered outputs
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_done_q, frame_done_d;

  logic       tick;
  logic       boundary;
  logic       slot_blank;
  logic [3:0] cur_digit;
  logic       lz_blank;

  assign tick     = (presc_q == PrescMax);
  assign boundary = tick && (idx_q == 2'd3);

  // Segment pattern for one BCD digit; 10..15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Prescaler wraps every slot; digit index advances on each tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
  end

  // Pending/shadow handoff: only a frame boundary may change what is displayed.
  always_comb begin
    shadow_d    = shadow_q;
    pend_val_d  = pend_val_q;
    pend_flag_d = pend_flag_q;
    if (boundary) begin
      // A load landing exactly on the boundary bypasses the pending stage.
      if (load) begin
        shadow_d = data_in;
      end else if (pend_flag_q) begin
        shadow_d = pend_val_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = data_in;
      pend_flag_d = 1'b1;
    end
  end

  // Select the shadow digit addressed by the current index.
  always_comb begin
    cur_digit = 4'd0;
    unique case (idx_q)
      2'd0: cur_digit = shadow_q[3:0];
      2'd1: cur_digit = shadow_q[7:4];
      2'd2: cur_digit = shadow_q[11:8];
      2'd3: cur_digit = shadow_q[15:12];
      default: cur_digit = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    lz_blank = 1'b0;
    unique case (idx_q)
      2'd1: lz_blank = (shadow_q[15:4] == 12'd0);
      2'd2: lz_blank = (shadow_q[15:8] == 8'd0);
      2'd3: lz_blank = (shadow_q[15:12] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  // Leading-zero blanking not built; every digit is decoded.
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Next values of the registered display outputs.
  always_comb begin
    slot_blank   = (presc_q < BlankLen);
    an_d         = slot_blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d        = lz_blank ? SegOff : seg_decode(cur_digit);
    // The decimal point ignores blanking; the anode already gates it.
    dp_d         = (idx_q != DpIdx);
    frame_done_d = boundary;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'd0;
      pend_val_q   <= 16'd0;
      pend_flag_q  <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= SegOff;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_val_q   <= pend_val_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with a cycle-count based reference model.
module tb_seg7_scan_display;

  localparam int P   = 4;
  localparam int B   = 1;
  localparam int DPP = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: cycle position within the frame and displayed/pending data.
  int          m_k = 0;
  logic [15:0] m_shown = 16'd0;
  logic [15:0] m_pend = 16'd0;
  logic        m_pv = 1'b0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;
  logic        m_fd = 1'b0;

  seg7_scan_display #(
    .SCAN_PERIOD (P),
    .BLANK_CYCLES(B),
    .DP_POS      (DPP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .load      (load),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i);
    int d;
    d = int'((v >> (4 * i)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (v >> (4 * i)) == 16'd0) return 7'b1111111;
`endif
    return digit_pattern(d);
  endfunction

  // Advance the model by one clock edge using the inputs presented to the DUT.
  task automatic model_edge();
    int presc;
    int idx;
    logic [3:0] onehot;
    if (!rst) begin
      m_k = 0; m_shown = 16'd0; m_pend = 16'd0; m_pv = 1'b0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_fd = 1'b0;
    end else begin
      presc  = m_k % P;
      idx    = m_k / P;
      onehot = 4'b0001 << idx;
      m_an   = (presc < B) ? 4'hF : ~onehot;
      m_seg  = ref_seg(m_shown, idx);
      m_dp   = (idx == DPP) ? 1'b0 : 1'b1;
      m_fd   = (m_k == FRAME - 1);
      if (m_fd) begin
        if (load) m_shown = data_in;
        else if (m_pv) m_shown = m_pend;
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = data_in;
        m_pv   = 1'b1;
      end
      m_k = (m_k + 1) % FRAME;
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge occur, then settle.
  task automatic cyc(input logic r, input logic ld, input logic [15:0] d);
    @(negedge clk);
    rst = r; load = ld; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Idle until the model says the next edge is a frame boundary.
  task automatic goto_boundary_edge();
    for (int i = 0; i < 2 * FRAME && m_k != FRAME - 1; i++) cyc(1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_reset();
    int n;
    cyc(1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'h4321);
    cyc(1'b1, 1'b0, 16'd0);
    // Hold reset for three cycles mid-scan, with a load pending.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h9999);
      n_vec++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got an=%b seg=%b dp=%b fd=%b want 1111/1111111/1/0",
                 an, seg, dp, frame_done);
      end
      n_vec++;
      if (dut.pend_flag_q !== 1'b0) begin
        n_err++;
        $display("FAIL reset_pend_flag: got %b want 0", dut.pend_flag_q);
      end
    end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
    n_vec++;
    if (n != 16) begin
      n_err++;
      $display("FAIL reset_frame_done_delay: got %0d cycles want 16", n);
    end
    // Pending load was discarded: the next frame still shows zero on digit 0.
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      if (an === 4'b1110) begin
        n_vec++;
        if (seg !== 7'b1000000) begin
          n_err++;
          $display("FAIL reset_discard: got seg=%b want 1000000", seg);
        end
      end
    end
  endtask

  task automatic test_digits();
    int hits;
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'h1259);
    for (int i = 0; i < 40 && frame_done !== 1'b1; i++) cyc(1'b1, 1'b0, 16'd0);
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL digits_boundary: got fd=%b want 1 within budget", frame_done);
    end
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      n_vec++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
        n_err++;
        $display("FAIL digits_model: got %b/%b/%b want %b/%b/%b", an, seg, dp, m_an, m_seg, m_dp);
      end
      if (an === 4'b1110) begin
        hits++;
        n_vec++;
        if (seg !== 7'b0010000) begin
          n_err++;
          $display("FAIL digits_d0: got seg=%b want 0010000", seg);
        end
      end
      if (an === 4'b1011) begin
        hits++;
        n_vec++;
        if (seg !== 7'b0100100 || dp !== 1'b0) begin
          n_err++;
          $display("FAIL digits_d2: got seg=%b dp=%b want 0100100/0", seg, dp);
        end
      end
    end
    n_vec++;
    if (hits != 2 * (P - B)) begin
      n_err++;
      $display("FAIL digits_slots: got %0d lit slots want %0d", hits, 2 * (P - B));
    end
  endtask

  task automatic test_last_wins();
    goto_boundary_edge();
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'h0003);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b1, 16'h0042);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      n_vec++;
      if (an !== m_an || seg !== m_seg || frame_done !== m_fd) begin
        n_err++;
        $display("FAIL last_wins_model: got %b/%b/%b want %b/%b/%b",
                 an, seg, frame_done, m_an, m_seg, m_fd);
      end
      if (an === 4'b1110) begin
        n_vec++;
        if (seg === 7'b0110000) begin
          n_err++;
          $display("FAIL last_wins_stale: got seg=%b want anything but 0110000", seg);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [15:0] v;
    v = {4'(($urandom % 10)), 4'(($urandom % 10)), 4'(($urandom % 10)), 4'(($urandom % 10))};
    cyc(1'b1, 1'b1, 16'h8888);
    goto_boundary_edge();
    cyc(1'b1, 1'b1, v);
    n_vec++;
    if (dut.pend_flag_q !== 1'b0 || frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL boundary_load_flag: got pend=%b fd=%b want 0/1", dut.pend_flag_q, frame_done);
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      for (int d = 0; d < 4; d++) begin
        if (an === ~(4'b0001 << d)) begin
          n_vec++;
          if (seg !== ref_seg(v, d)) begin
            n_err++;
            $display("FAIL boundary_load_digit%0d: got seg=%b want %b", d, seg, ref_seg(v, d));
          end
        end
      end
    end
  endtask

  task automatic test_dash();
    goto_boundary_edge();
    cyc(1'b1, 1'b1, 16'h12C4);
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      if (an === 4'b1101) begin
        n_vec++;
        if (seg !== 7'b0111111) begin
          n_err++;
          $display("FAIL dash: got seg=%b want 0111111", seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] hi_want;
`ifdef LEADING_ZERO_BLANK_EN
    hi_want = 7'b1111111;
`else
    hi_want = 7'b1000000;
`endif
    goto_boundary_edge();
    cyc(1'b1, 1'b1, 16'h0007);
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, 1'b0, 16'd0);
      if (an === 4'b1110) begin
        n_vec++;
        if (seg !== 7'b1111000 || dp !== 1'b1) begin
          n_err++;
          $display("FAIL lz_digit0: got seg=%b dp=%b want 1111000/1", seg, dp);
        end
      end else if (an !== 4'b1111) begin
        n_vec++;
        if (seg !== hi_want) begin
          n_err++;
          $display("FAIL lz_high an=%b: got seg=%b want %b", an, seg, hi_want);
        end
        if (an === 4'b1011) begin
          n_vec++;
          if (dp !== 1'b0) begin
            n_err++;
            $display("FAIL lz_dp: got dp=%b want 0", dp);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        ld;
    logic [15:0] d;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom % 120) != 0;
      ld = ($urandom % 7) == 0;
      d  = 16'($urandom);
      cyc(r, ld, d);
      n_vec++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp || frame_done !== m_fd) begin
        n_err++;
        $display("FAIL random cyc %0d: got %b/%b/%b/%b want %b/%b/%b/%b", i,
                 an, seg, dp, frame_done, m_an, m_seg, m_dp, m_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_last_wins();
    test_boundary_load();
    test_dash();
    test_leading_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter SCAN_PERIOD, default 100_000: clk cycles per digit slot, legal range 2 and above.
REQ-002 Parameter BLANK_CYCLES, default 2: cycles at the start of each slot with all anodes off, legal range 0 to SCAN_PERIOD-1.
REQ-003 Parameter DP_POS, default 2: digit index whose decimal point is lit, legal range 0..3.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 data_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-007 load  input  1  one-cycle strobe; captures data_in on the same edge.
REQ-008 an  output  4  anode enables, active-low; an[i] drives digit i.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at every frame boundary.

Function
REQ-012 The prescaler shall count 0..SCAN_PERIOD-1 and wrap; a tick is the cycle where prescaler = SCAN_PERIOD-1.
REQ-013 On each tick, digit index idx shall advance 0->1->2->3->0.
REQ-014 A frame boundary is a tick with idx=3; frame_done shall be 1 in the cycle after that tick and 0 otherwise.
REQ-015 load=1 shall store data_in into a pending register and set the pending flag.
REQ-016 At a frame boundary with the pending flag set, the shadow register shall take the pending value and the flag shall clear.
REQ-017 load coinciding with a frame boundary shall write data_in directly into the shadow register and leave the flag clear.
REQ-018 Multiple loads within one frame: last one wins; the displayed value shall never change mid-frame.
REQ-019 an, seg and dp shall be registered: one cycle of latency from idx, prescaler and shadow state.
REQ-020 an shall be 4'b1111 while prescaler < BLANK_CYCLES; otherwise an[idx]=0 and all other bits are 1.
REQ-021 seg shall decode shadow digit idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 Digit values 10..15 shall display '-' (seg=0111111).
REQ-023 dp shall be 0 when idx=DP_POS and 1 otherwise; dp is independent of blanking (the anode gates it).

Reset
REQ-024 While rst=0 at an edge, prescaler, idx, shadow, pending value and pending flag shall become 0.
REQ-025 While rst=0, outputs shall be an=1111, seg=1111111, dp=1, frame_done=0.
REQ-026 Reset mid-frame shall discard any pending load.
REQ-027 The first clk after rst rises shall restart the scan at idx 0, prescaler 0.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN, when defined: digits 3, 2, 1 shall show seg=1111111 when they and every higher digit equal 0; digit 0 shall never be blanked.
REQ-029 With LEADING_ZERO_BLANK_EN defined, dp shall be unaffected by leading-zero blanking.
REQ-030 Without LEADING_ZERO_BLANK_EN, every digit shall be decoded per REQ-021 and REQ-022.

Verification
REQ-031 Bench parameters are SCAN_PERIOD=4, BLANK_CYCLES=1, DP_POS=2 unless a scenario states otherwise.
REQ-032 Reset, then load data_in=16'h1259: after the next frame boundary, digit 0 shows an=1110 with seg=0010000, and digit 2 shows seg=0100100 with dp=0.
REQ-033 Hold rst=0 for 3 cycles mid-scan: outputs are 1111/1111111/1, and frame_done pulses 16 cycles after rst releases.
REQ-034 Load 16'h0003 then 16'h0042 within one frame: only 0042 appears after the boundary; no digit shows 0003.
REQ-035 Load asserted exactly on the boundary tick: the new value appears in the next frame, and the pending flag stays 0.
REQ-036 Digit value 4'hC: that digit shows seg=0111111.
REQ-037 Load 16'h0007 with the macro defined: digits 3, 2, 1 show seg=1111111 and digit 0 shows 1111000; without the macro, digits 3, 2, 1 show 1000000.
